// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, credit-limited imem requests, in-order
// instruction buffer and redirect flush of buffered and in-flight words.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  op,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic        fetch_busy
);
    localparam int          CW       = $clog2(FIFO_DEPTH + 1);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] LP_DEPTH = FIFO_DEPTH[CW:0];

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_pq_wr;
    logic [AW-1:0] r_pq_rd;
    logic [AW-1:0] r_fq_wr;
    logic [AW-1:0] r_fq_rd;
    logic [31:0]   r_pq [FIFO_DEPTH];
    logic [63:0]   r_fq [FIFO_DEPTH];

    logic [CW:0]   w_credit;
    logic          w_hs;
    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_rsp_pc;
    logic [63:0]   w_head;
    logic          w_unused_lsb;

    // Credit covers buffered words plus every in-flight request, drops included.
    assign w_credit       = {1'b0, r_out} + {1'b0, r_cnt};
    assign imem_req_valid = ~rst & (w_credit < LP_DEPTH);
    assign imem_req_addr  = r_fetch_pc;
    assign w_hs           = imem_req_valid & imem_req_ready;
    assign w_pop          = instr_valid & instr_ready;
    assign w_push         = imem_rsp_valid & ~redirect_valid & (r_drop == '0);
    assign w_rsp_pc       = r_pq[r_pq_rd];
    assign w_head         = r_fq[r_fq_rd];
    assign w_unused_lsb   = ^redirect_pc[1:0];

    assign instr_valid = (r_cnt != '0);
    assign instr       = instr_valid ? w_head[63:32] : 32'h0;
    assign instr_pc    = instr_valid ? w_head[31:0]  : 32'h0;
    assign op          = instr[6:0];
    assign func3       = instr[14:12];
    assign func7       = instr[31:25];
    assign fetch_busy  = (r_out != '0) | (r_drop != '0);

    always_ff @(posedge clk) begin
        if (w_hs)
            r_pq[r_pq_wr] <= r_fetch_pc;
        if (w_push)
            r_fq[r_fq_wr] <= {imem_rsp_data, w_rsp_pc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_cnt      <= '0;
            r_pq_wr    <= '0;
            r_pq_rd    <= '0;
            r_fq_wr    <= '0;
            r_fq_rd    <= '0;
        end else begin
            // The PC queue survives redirects: dropped responses still retire their tag.
            if (w_hs)
                r_pq_wr <= r_pq_wr + AW'(1);
            if (imem_rsp_valid)
                r_pq_rd <= r_pq_rd + AW'(1);
            r_out <= r_out + CW'(w_hs) - CW'(imem_rsp_valid);

            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_drop     <= r_out + CW'(w_hs) - CW'(imem_rsp_valid);
                r_cnt      <= '0;
                r_fq_wr    <= '0;
                r_fq_rd    <= '0;
            end else begin
                if (w_hs)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (imem_rsp_valid && (r_drop != '0))
                    r_drop <= r_drop - CW'(1);
                if (w_push)
                    r_fq_wr <= r_fq_wr + AW'(1);
                if (w_pop)
                    r_fq_rd <= r_fq_rd + AW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: in-order memory model with random latency
// and an epoch-based model of which words reach the consumer.
module tb_fetch_stage;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        fetch_busy;

    fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .op(op), .func3(func3), .func7(func7),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } req_t;

    req_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          buffered = 0;
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    int          p_ready = 100;
    int          p_ir = 100;
    int          p_redir = 0;
    int          lat_max = 1;
    logic        force_redir = 1'b0;
    logic [31:0] force_tgt = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        logic [31:0] m;
        m = a * 32'h9E37_79B1;
        return (a == 32'h0) ? 32'h00A0_0093 : (m ^ 32'h5A5A_0F0F);
    endfunction

    task automatic model_reset();
        q.delete();
        exp_req  = RPC;
        exp_pc   = RPC;
        buffered = 0;
        cyc      = 0;
    endtask

    // One cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic step();
        req_t        h;
        logic        mvalid, hs, pop, rsp, redir, kept;
        logic [31:0] d, tgt;
        int          lat;
        imem_req_ready = ($urandom_range(99) < p_ready);
        instr_ready    = ($urandom_range(99) < p_ir);
        rsp            = (q.size() > 0) && (q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? data_of(q[0].addr) : $urandom;
        redir          = force_redir || ($urandom_range(99) < p_redir);
        redirect_valid = redir;
        redirect_pc    = force_redir ? force_tgt : $urandom;
        force_redir    = 1'b0;
        @(negedge clk);
        mvalid = (q.size() + buffered) < DEPTH;
        chk("req_valid", imem_req_valid, mvalid);
        if (mvalid)
            chk("req_addr", imem_req_addr, exp_req);
        chk("instr_valid", instr_valid, buffered != 0);
        chk("fetch_busy", fetch_busy, q.size() != 0);
        d = data_of(exp_pc);
        if (buffered != 0) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, d);
            chk("op", op, d[6:0]);
            chk("func3", func3, d[14:12]);
            chk("func7", func7, d[31:25]);
        end else begin
            chk("op_empty", op, 0);
        end
        hs   = mvalid && imem_req_ready;
        pop  = (buffered != 0) && instr_ready;
        kept = 1'b0;
        if (rsp) begin
            h    = q.pop_front();
            kept = !redir && (h.ep == epoch);
        end
        if (pop) begin
            exp_pc += 32'd4;
            buffered--;
            n_pop++;
        end
        if (hs) begin
            lat = int'($urandom_range(lat_max, 1));
            q.push_back('{exp_req, epoch, cyc + lat});
            exp_req += 32'd4;
        end
        if (redir) begin
            tgt      = {redirect_pc[31:2], 2'b00};
            exp_req  = tgt;
            exp_pc   = tgt;
            buffered = 0;
            epoch++;
        end else if (kept) begin
            buffered++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic redirect_to(input logic [31:0] t);
        force_tgt   = t;
        force_redir = 1'b1;
        step();
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_busy", fetch_busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming with a 1-cycle memory, then consumer stall and resume.
        run(20);
        p_ir = 0;
        run(10);
        p_ir = 100;
        run(10);

        // Redirects with slow memory so responses are in flight.
        lat_max = 3;
        run(5);
        redirect_to(32'h0000_0100);
        run(12);
        redirect_to(32'h0000_0203);
        run(8);
        redirect_to(32'hFFFF_FFF8);
        run(8);
        redirect_to(32'hFFFF_FFFC);
        run(4);

        // Random traffic.
        p_ready = 60;
        p_ir    = 70;
        p_redir = 5;
        run(3000);

        // Fill the buffer, then reset asynchronously mid-cycle.
        p_ready = 100;
        p_ir    = 0;
        p_redir = 0;
        lat_max = 1;
        run(6);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_instr_valid", instr_valid, 0);
        chk("arst_req_addr", imem_req_addr, RPC);
        chk("arst_req_valid", imem_req_valid, 0);
        chk("arst_busy", fetch_busy, 0);
        chk("arst_instr", instr, 0);
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        p_ir = 100;
        run(20);

        chk("progress", n_pop > 200, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
